char_video_gen: RTL and testbench

- Parametrised character-mapped video generator. Successor to the fixed 32x24 mono/colour Ace video block.
- Generalised in grid size, glyph height and raster timing. Adds a registered memory fetch pipeline, border colour, a bright bit, a flash attribute and a frame-start strobe.
- Sits between the screen/char/attribute RAMs and the scandoubler/OSD path.

---
 rtl/char_video_gen_if.sv | 23 ++
 rtl/char_video_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_char_video_gen.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/char_video_gen_if.sv
// Memory-side bus of the character video generator: screen, attribute and
// character RAM ports. All three RAMs are synchronous with 1-clk read latency.
interface char_video_gen_if #(
    parameter int AW  = 10,
    parameter int CAW = 10
);
    logic [AW-1:0]  scr_addr;
    logic [7:0]     scr_data;
    logic [AW-1:0]  attr_addr;
    logic [7:0]     attr_data;
    logic [CAW-1:0] cram_addr;
    logic [7:0]     cram_data;

    modport master (
        output scr_addr, attr_addr, cram_addr,
        input  scr_data, attr_data, cram_data
    );

    modport slave (
        input  scr_addr, attr_addr, cram_addr,
        output scr_data, attr_data, cram_data
    );
endinterface

// File: rtl/char_video_gen.sv
// Parametrised character-mapped video generator.
// Raster counters, a one-cell-ahead RAM fetch pipeline, pixel shifter,
// border/blanking/sync generation and a frame-start strobe.
// Optional feature macro: FLASH_EN (flash attribute + frame flash counter).
module char_video_gen #(
    parameter int COLS         = 32,
    parameter int ROWS         = 24,
    parameter int CHAR_H       = 8,
    parameter int H_TOTAL      = 416,
    parameter int V_TOTAL      = 312,
    parameter int HS_START     = 308,
    parameter int HS_END       = 340,
    parameter int VS_START     = 248,
    parameter int VS_END       = 256,
    parameter int FLASH_FRAMES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce_pix,
    char_video_gen_if.master  mem,
    input  logic [2:0]        border,
    output logic [1:0]        R,
    output logic [1:0]        G,
    output logic [1:0]        B,
    output logic              video_out,
    output logic              hsync,
    output logic              vsync,
    output logic              hblank,
    output logic              vblank,
    output logic              frame_start
);
    localparam int AW      = $clog2(COLS * ROWS);
    localparam int LW      = $clog2(CHAR_H);
    localparam int LWX     = (LW > 0) ? LW : 1;
    localparam int CAW     = 7 + LW;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int H_ACT   = 8 * COLS;
    localparam int V_ACT   = ROWS * CHAR_H;
    localparam int H_BLANK = H_ACT + (HS_START - H_ACT) / 2;
    localparam int V_BLANK = V_ACT + (VS_START - V_ACT) / 2;

    logic [HW-1:0]  hcnt;
    logic [VW-1:0]  vcnt, vcnt_nxt;
    logic           h_wrap, v_last, h_act, v_act, hb, vb, in_pre;
    logic [2:0]     phase;
    logic [AW-1:0]  row_base, row_base_nxt, scr_addr;
    logic [CAW-1:0] cram_addr, cram_nxt;
    logic [LWX-1:0] fetch_line;
    logic [7:0]     attr_lat, glyph_lat, shreg, out_attr;
    logic           inv_lat, out_inv, out_flash, flash_phase, pix;
    logic [2:0]     col;

    assign mem.scr_addr  = scr_addr;
    assign mem.attr_addr = scr_addr;
    assign mem.cram_addr = cram_addr;

    // Raster decode, next-line lookahead for the end-of-line prefetch
    always_comb begin
        phase    = hcnt[2:0];
        h_wrap   = (32'(hcnt) == H_TOTAL - 1);
        v_last   = (32'(vcnt) == V_TOTAL - 1);
        vcnt_nxt = v_last ? '0 : vcnt + VW'(1);
        h_act    = (32'(hcnt) < H_ACT);
        v_act    = (32'(vcnt) < V_ACT);
        hb       = (32'(hcnt) >= H_BLANK);
        vb       = (32'(vcnt) >= V_BLANK);
        // last 8 pixels of a line fetch cell 0 of the following line
        in_pre     = (32'(hcnt) >= H_TOTAL - 8);
        fetch_line = in_pre ? vcnt_nxt[LWX-1:0] : vcnt[LWX-1:0];
        row_base_nxt = row_base;
        if (vcnt_nxt == '0)
            row_base_nxt = '0;
        else if (((32'(vcnt_nxt) & (CHAR_H - 1)) == 0) && (32'(vcnt_nxt) < V_ACT))
            row_base_nxt = row_base + AW'(COLS);
    end

    generate
        if (LW > 0) begin : g_line
            assign cram_nxt = {mem.scr_data[6:0], fetch_line[LW-1:0]};
        end else begin : g_noline
            assign cram_nxt = mem.scr_data[6:0];
        end
    endgenerate

    // Horizontal/vertical counters and text-row base address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt     <= '0;
            vcnt     <= '0;
            row_base <= '0;
        end else if (ce_pix) begin
            if (h_wrap) begin
                hcnt     <= '0;
                vcnt     <= vcnt_nxt;
                row_base <= row_base_nxt;
            end else begin
                hcnt <= hcnt + HW'(1);
            end
        end
    end

    // Fetch pipeline: address at phase 0, screen/attr at 2, glyph at 4
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scr_addr  <= '0;
            cram_addr <= '0;
            attr_lat  <= '0;
            inv_lat   <= 1'b0;
            glyph_lat <= '0;
        end else if (ce_pix) begin
            case (phase)
                3'd0: begin
                    if (in_pre)
                        scr_addr <= row_base_nxt;
                    else if (v_act && (32'(hcnt) < 8 * (COLS - 1)))
                        scr_addr <= scr_addr + AW'(1);
                end
                3'd2: begin
                    attr_lat  <= mem.attr_data;
                    inv_lat   <= mem.scr_data[7];
                    cram_addr <= cram_nxt;
                end
                3'd4: glyph_lat <= mem.cram_data;
                default: ;
            endcase
        end
    end

    // Output stage: load the prefetched cell at phase 7, shift MSB-first otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg     <= '0;
            out_attr  <= '0;
            out_inv   <= 1'b0;
            out_flash <= 1'b0;
        end else if (ce_pix) begin
            if (phase == 3'd7) begin
                shreg     <= glyph_lat;
                out_attr  <= attr_lat;
                out_inv   <= inv_lat;
                out_flash <= attr_lat[7];
            end else begin
                shreg <= {shreg[6:0], 1'b0};
            end
        end
    end

`ifdef FLASH_EN
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    logic [FW-1:0] flash_cnt;

    // Frame counter toggling the flash phase every FLASH_FRAMES frames
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flash_cnt   <= '0;
            flash_phase <= 1'b0;
        end else if (ce_pix && h_wrap && v_last) begin
            if (32'(flash_cnt) == FLASH_FRAMES - 1) begin
                flash_cnt   <= '0;
                flash_phase <= ~flash_phase;
            end else begin
                flash_cnt <= flash_cnt + FW'(1);
            end
        end
    end
`else
    assign flash_phase = 1'b0;
`endif

    // Pixel value and selected GRB colour for the current cell
    always_comb begin
        pix = shreg[7] ^ out_inv ^ (out_flash & flash_phase);
        col = pix ? out_attr[2:0] : out_attr[5:3];
    end

    // Registered video, blanking, sync and frame strobe (one pixel late)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            R           <= '0;
            G           <= '0;
            B           <= '0;
            video_out   <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            frame_start <= 1'b0;
        end else if (ce_pix) begin
            hblank      <= hb;
            vblank      <= vb;
            frame_start <= h_wrap && v_last;
            if (hb || vb) begin
                R         <= '0;
                G         <= '0;
                B         <= '0;
                video_out <= 1'b0;
            end else if (h_act && v_act) begin
                R         <= {out_attr[6] & col[1], col[1]};
                G         <= {out_attr[6] & col[2], col[2]};
                B         <= {out_attr[6] & col[0], col[0]};
                video_out <= pix;
            end else begin
                R         <= {1'b0, border[1]};
                G         <= {1'b0, border[2]};
                B         <= {1'b0, border[0]};
                video_out <= 1'b0;
            end
            if (32'(hcnt) == HS_START) begin
                hsync <= 1'b0;
                if (32'(vcnt) == VS_START)
                    vsync <= 1'b0;
                else if (32'(vcnt) == VS_END)
                    vsync <= 1'b1;
            end else if (32'(hcnt) == HS_END) begin
                hsync <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_char_video_gen.sv
// Scoreboard bench for char_video_gen on a small raster (4x3 cells, 4-line
// glyphs, 64x24 timing). Expected outputs are keyed on the count n of ce_pix
// edges since reset release; outputs seen after n edges belong to pixel n-1.
module tb_char_video_gen;
    localparam int COLS = 4, ROWS = 3, CHAR_H = 4;
    localparam int HT = 64, VT = 24, HSS = 48, HSE = 56, VSS = 18, VSE = 20, FFR = 2;
    localparam int FRAME = HT * VT;
`ifdef FLASH_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif
    localparam logic [11:0] M_RGB = 12'hFC0, M_VID = 12'h020, M_HS = 12'h010,
                            M_VS = 12'h008, M_HB = 12'h004, M_VB = 12'h002, M_FS = 12'h001;
    localparam logic [5:0] WHITE = 6'b111111, WH_NB = 6'b010101, BORD = 6'b000101,
                           RED = 6'b010000, BLUE = 6'b000001;

    typedef struct { int n; logic [11:0] mask; logic [11:0] val; } exp_t;

    logic clk = 1'b0, reset_n = 1'b0, ce_pix = 1'b1;
    logic [2:0] border = 3'b101;
    logic [1:0] R, G, B;
    logic video_out, hsync, vsync, hblank, vblank, frame_start;
    logic [7:0] scr_mem [16];
    logic [7:0] attr_mem [16];
    logic [7:0] cram_mem [512];
    logic [11:0] got;
    exp_t eq[$];
    string nq[$];
    int n = 0, tests = 0, fails = 0;
    bit hit = 1'b0;

    char_video_gen_if #(.AW(4), .CAW(9)) mem_if ();

    char_video_gen #(
        .COLS(COLS), .ROWS(ROWS), .CHAR_H(CHAR_H), .H_TOTAL(HT), .V_TOTAL(VT),
        .HS_START(HSS), .HS_END(HSE), .VS_START(VSS), .VS_END(VSE), .FLASH_FRAMES(FFR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .mem(mem_if), .border(border),
        .R(R), .G(G), .B(B), .video_out(video_out), .hsync(hsync), .vsync(vsync),
        .hblank(hblank), .vblank(vblank), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // synchronous RAMs, 1-clk latency
    always @(posedge clk) begin
        mem_if.scr_data  <= scr_mem[mem_if.scr_addr];
        mem_if.attr_data <= attr_mem[mem_if.attr_addr];
        mem_if.cram_data <= cram_mem[mem_if.cram_addr];
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) n <= 0;
        else if (ce_pix) n <= n + 1;
    end

    function automatic int pos(input int f, input int v, input int h);
        return f * FRAME + v * HT + h + 1;
    endfunction

    task automatic push(input int at, input string nm, input logic [11:0] mask, input logic [11:0] val);
        exp_t e;
        e.n = at; e.mask = mask; e.val = val;
        eq.push_back(e);
        nq.push_back(nm);
    endtask

    task automatic px(input int at, input string nm, input logic [5:0] rgb, input logic vid);
        push(at, nm, M_RGB | M_VID, {rgb, vid, 5'b0});
    endtask

    task automatic wait_n(input int target);
        int guard = 0;
        while (n < target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (n < target) begin
            tests++; fails++;
            $display("FAIL timeout waiting for n=%0d, at n=%0d", target, n);
        end
    endtask

    // monitor: compare the head entry whenever the DUT presents its pixel
    always @(negedge clk) begin
        got = {R, G, B, video_out, hsync, vsync, hblank, vblank, frame_start};
        while (eq.size() > 0 && eq[0].n < n) begin
            if (!hit) begin
                tests++; fails++;
                $display("FAIL %s never sampled (n=%0d)", nq[0], eq[0].n);
            end
            void'(eq.pop_front());
            void'(nq.pop_front());
            hit = 1'b0;
        end
        if (eq.size() > 0 && eq[0].n == n) begin
            tests++;
            hit = 1'b1;
            if ((got & eq[0].mask) !== (eq[0].val & eq[0].mask)) begin
                fails++;
                $display("FAIL %s n=%0d got %b required %b (mask %b)", nq[0], n, got, eq[0].val, eq[0].mask);
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) begin scr_mem[i] = 8'h00; attr_mem[i] = 8'h00; end
        for (int i = 0; i < 512; i++) cram_mem[i] = 8'h00;
        scr_mem[0]  = 8'h41; attr_mem[0]  = 8'h47;
        scr_mem[1]  = 8'hC1; attr_mem[1]  = 8'h47;
        scr_mem[2]  = 8'h41; attr_mem[2]  = 8'h87;
        scr_mem[4]  = 8'h42; attr_mem[4]  = 8'h02;
        scr_mem[11] = 8'h43; attr_mem[11] = 8'h01;
        cram_mem[{7'h41, 2'd0}] = 8'h81;
        cram_mem[{7'h42, 2'd1}] = 8'hF0;
        cram_mem[{7'h43, 2'd3}] = 8'h01;

        push(0, "reset_state", 12'hFFF, 12'h01E);
        px(pos(0, 0, 0),  "c0_first_frame", 6'd0, 1'b0);
        px(pos(0, 0, 8),  "inv_b0", 6'd0, 1'b0);
        px(pos(0, 0, 9),  "inv_b1", WHITE, 1'b1);
        px(pos(0, 0, 12), "inv_b4", WHITE, 1'b1);
        px(pos(0, 0, 15), "inv_b7", 6'd0, 1'b0);
        px(pos(0, 0, 16), "flash_f0_b7", WH_NB, 1'b1);
        px(pos(0, 0, 17), "flash_f0_b6", 6'd0, 1'b0);
        push(pos(0, 0, 32), "border_left", M_RGB | M_VID | M_HB, {BORD, 6'b0});
        push(pos(0, 0, 39), "border_right", M_RGB | M_VID | M_HB, {BORD, 6'b0});
        push(pos(0, 0, 40), "hblank_on", M_RGB | M_VID | M_HB, 12'h004);
        push(pos(0, 0, 47), "hs_before", M_HS, 12'h010);
        push(pos(0, 0, 48), "hs_fall", M_HS, 12'h000);
        push(pos(0, 0, 55), "hs_low_end", M_HS, 12'h000);
        push(pos(0, 0, 56), "hs_rise", M_HS, 12'h010);
        px(pos(0, 5, 0),  "row1_c0_on", RED, 1'b1);
        px(pos(0, 5, 4),  "row1_c0_off", 6'd0, 1'b0);
        px(pos(0, 11, 30), "last_cell_b1", 6'd0, 1'b0);
        px(pos(0, 11, 31), "last_cell_b0", BLUE, 1'b1);
        push(pos(0, 12, 0), "vborder", M_RGB | M_VID | M_VB, {BORD, 6'b0});
        push(pos(0, 14, 0), "vblank_off", M_VB, 12'h000);
        push(pos(0, 15, 0), "vblank_on", M_RGB | M_VID | M_VB, 12'h002);
        push(pos(0, 18, 47), "vs_before", M_VS, 12'h008);
        push(pos(0, 18, 48), "vs_fall", M_VS, 12'h000);
        push(pos(0, 20, 47), "vs_low_end", M_VS, 12'h000);
        push(pos(0, 20, 48), "vs_rise", M_VS, 12'h008);
        push(pos(0, 23, 62), "fs_before", M_FS, 12'h000);
        push(pos(0, 23, 63), "fs_pulse0", M_FS, 12'h001);
        push(pos(1, 0, 0), "frozen_c0", M_RGB | M_VID | M_FS, {WHITE, 1'b1, 5'b0});
        px(pos(1, 0, 1),  "c0_b6", 6'd0, 1'b0);
        px(pos(1, 0, 6),  "c0_b1", 6'd0, 1'b0);
        px(pos(1, 0, 7),  "c0_b0", WHITE, 1'b1);
        px(pos(1, 0, 16), "flash_f1_b7", WH_NB, 1'b1);
        push(pos(1, 23, 63), "fs_pulse1", M_FS, 12'h001);
        px(pos(2, 0, 16), "flash_f2_b7", FL ? 6'd0 : WH_NB, !FL);
        px(pos(2, 0, 17), "flash_f2_b6", FL ? WH_NB : 6'd0, FL);
        px(pos(3, 0, 16), "flash_f3_b7", FL ? 6'd0 : WH_NB, !FL);
        px(pos(4, 0, 16), "flash_f4_b7", WH_NB, 1'b1);

        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // hold ce_pix low for 5 clks on the first pixel of frame 1
        wait_n(pos(1, 0, 0));
        ce_pix = 1'b0;
        repeat (5) @(negedge clk);
        ce_pix = 1'b1;

        wait_n(pos(4, 0, 16) + 3);

        // asynchronous reset mid-frame, checked in the same clk cycle
        @(posedge clk);
        #1 reset_n = 1'b0;
        push(0, "midframe_reset", 12'hFFF, 12'h01E);
        repeat (3) @(negedge clk);
        px(pos(0, 0, 0), "rst_c0_clean", 6'd0, 1'b0);
        px(pos(0, 0, 9), "rst_inv_b1", WHITE, 1'b1);
        push(pos(0, 0, 47), "rst_hs_before", M_HS, 12'h010);
        push(pos(0, 0, 48), "rst_hs_fall", M_HS, 12'h000);
        reset_n = 1'b1;
        wait_n(pos(0, 0, 48) + 3);

        if (eq.size() != 0) begin
            tests++; fails++;
            $display("FAIL pending_checks left=%0d required 0", eq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
